// File: rtl/hazard_control_unit_pkg.sv
// Shared types and constants for the pipeline hazard/debug controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package hazard_pkg;

   // Default register-file address width (32 architectural registers).
   localparam int DEF_REG_ADDR_W = 5;

   // Register $zero: never a real producer, so it can never cause a load-use stall.
   localparam int REG_ZERO = 0;

   // Debug sequencing states.
   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_HALTED = 2'd1,
      ST_STEP   = 2'd2
   } state_t;

   // Pick the state the controller wakes up in after reset.
   function automatic state_t reset_state(input int start_halted);
      return (start_halted != 0) ? ST_HALTED : ST_RUN;
   endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Bundle of pipeline-observation inputs and stall/flush controls around the hazard unit.
// Latency: n/a (wires only); optional counter outputs exist only with HAZARD_COUNTERS_EN.
// Backpressure: n/a; master side is the pipeline/debug logic, slave side is the controller.
interface hazard_control_unit_if #(
   parameter int REG_ADDR_W = hazard_pkg::DEF_REG_ADDR_W,
   parameter int CNT_W      = 32
);
   // Observed pipeline fields and debug requests
   logic [REG_ADDR_W-1:0] id_rs;
   logic [REG_ADDR_W-1:0] id_rt;
   logic                  id_uses_rt;
   logic [REG_ADDR_W-1:0] ex_rt;
   logic                  ex_mem_read;
   logic                  branch_taken;
   logic                  halt_detected;
   logic                  dbg_run;
   logic                  dbg_step;

   // Controls back to the pipe registers
   logic                  pipe_ena;
   logic                  pc_disa;
   logic                  if_id_disa;
   logic                  if_id_flush;
   logic                  id_ex_flush;
   logic                  halted;

`ifdef HAZARD_COUNTERS_EN
   logic [CNT_W-1:0]      stall_count;
   logic [CNT_W-1:0]      flush_count;
`endif

   modport master (
      output id_rs, id_rt, id_uses_rt, ex_rt, ex_mem_read,
             branch_taken, halt_detected, dbg_run, dbg_step,
      input  pipe_ena, pc_disa, if_id_disa, if_id_flush, id_ex_flush, halted
`ifdef HAZARD_COUNTERS_EN
      , input stall_count, flush_count
`endif
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, ex_rt, ex_mem_read,
             branch_taken, halt_detected, dbg_run, dbg_step,
      output pipe_ena, pc_disa, if_id_disa, if_id_flush, id_ex_flush, halted
`ifdef HAZARD_COUNTERS_EN
      , output stall_count, flush_count
`endif
   );

endinterface

// File: rtl/hazard_control_unit_load_use_detector.sv
// Flags a load in EX whose destination is a source of the instruction in ID.
// Latency: purely combinational, same cycle.
// Backpressure: none; the result feeds the stall muxing in the top level.
module load_use_detector
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rt,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   input  logic                  ex_mem_read,
   output logic                  lu
);

   // A load into $zero produces nothing; rt only matters when ID actually reads it.
   always_comb begin
      logic dest_live;
      logic rs_hit;
      logic rt_hit;
      dest_live = ex_mem_read && (ex_rt != REG_ADDR_W'(REG_ZERO));
      rs_hit    = (ex_rt == id_rs);
      rt_hit    = id_uses_rt && (ex_rt == id_rt);
      lu        = dest_live && (rs_hit || rt_hit);
   end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer: load-use stall, taken-branch flush and RUN/HALTED/STEP debug FSM.
// Latency: all controls combinational from state + inputs (stall acts on the same edge).
// Backpressure: pipe_ena=0 freezes every pipe register; optional counters with HAZARD_COUNTERS_EN.
module hazard_control_unit
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W   = DEF_REG_ADDR_W,
   parameter int START_HALTED = 0,
   parameter int CNT_W        = 32
) (
   input logic                 clk,
   input logic                 reset,
   hazard_control_unit_if.slave bus
);

   localparam state_t RESET_ST = reset_state(START_HALTED);

   state_t state;
   state_t state_nxt;
   logic   lu;
   logic   ena;

   load_use_detector #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_lud (
      .id_rs       (bus.id_rs),
      .id_rt       (bus.id_rt),
      .id_uses_rt  (bus.id_uses_rt),
      .ex_rt       (bus.ex_rt),
      .ex_mem_read (bus.ex_mem_read),
      .lu          (lu)
   );

   // State register; reset returns to the configured wake-up state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RESET_ST;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: STEP grants exactly one enabled clock and always falls back to HALTED.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN: begin
            if (bus.halt_detected) state_nxt = ST_HALTED;
         end
         ST_HALTED: begin
            if (bus.dbg_run)       state_nxt = ST_RUN;
            else if (bus.dbg_step) state_nxt = ST_STEP;
         end
         ST_STEP: begin
            state_nxt = ST_HALTED;
         end
         default: begin
            state_nxt = RESET_ST;
         end
      endcase
   end

   // Output muxing: load-use beats a taken branch (branch re-resolves after the bubble);
   // everything is quiet while frozen or in reset.
   always_comb begin
      ena             = 1'b0;
      bus.pipe_ena    = 1'b0;
      bus.pc_disa     = 1'b0;
      bus.if_id_disa  = 1'b0;
      bus.if_id_flush = 1'b0;
      bus.id_ex_flush = 1'b0;
      bus.halted      = 1'b0;

      if (!reset) begin
         ena = (state == ST_RUN) || (state == ST_STEP);
      end
      bus.pipe_ena = ena;

      if (ena) begin
         if (lu) begin
            bus.pc_disa     = 1'b1;
            bus.if_id_disa  = 1'b1;
            bus.id_ex_flush = 1'b1;
         end else if (bus.branch_taken) begin
            bus.if_id_flush = 1'b1;
         end
      end

      bus.halted = reset ? (RESET_ST == ST_HALTED) : (state == ST_HALTED);
   end

`ifdef HAZARD_COUNTERS_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   // Event counters; free-running wrap at 2^CNT_W.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (lu && ena)       stall_cnt <= stall_cnt + 1'b1;
         if (bus.if_id_flush) flush_cnt <= flush_cnt + 1'b1;
      end
   end

   assign bus.stall_count = stall_cnt;
   assign bus.flush_count = flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench: two instances (wake in RUN / wake in HALTED) share one stimulus stream.
// Directed scenarios first, then randomized cycles against a behavioural model.
// Counter checks are compiled in only with HAZARD_COUNTERS_EN.
module tb_hazard_control_unit;
   localparam int AW = 5;
   localparam int CW = 32;
   localparam int M_RUN = 0, M_HALTED = 1, M_STEP = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] id_rs, id_rt, ex_rt;
   logic          id_uses_rt, ex_mem_read, branch_taken, halt_detected, dbg_run, dbg_step;

   int errors = 0;
   int checks = 0;

   hazard_control_unit_if #(.REG_ADDR_W(AW), .CNT_W(CW)) if0 ();
   hazard_control_unit_if #(.REG_ADDR_W(AW), .CNT_W(CW)) if1 ();

   assign if0.id_rs = id_rs;                 assign if1.id_rs = id_rs;
   assign if0.id_rt = id_rt;                 assign if1.id_rt = id_rt;
   assign if0.id_uses_rt = id_uses_rt;       assign if1.id_uses_rt = id_uses_rt;
   assign if0.ex_rt = ex_rt;                 assign if1.ex_rt = ex_rt;
   assign if0.ex_mem_read = ex_mem_read;     assign if1.ex_mem_read = ex_mem_read;
   assign if0.branch_taken = branch_taken;   assign if1.branch_taken = branch_taken;
   assign if0.halt_detected = halt_detected; assign if1.halt_detected = halt_detected;
   assign if0.dbg_run = dbg_run;             assign if1.dbg_run = dbg_run;
   assign if0.dbg_step = dbg_step;           assign if1.dbg_step = dbg_step;

   hazard_control_unit #(.REG_ADDR_W(AW), .START_HALTED(0), .CNT_W(CW)) dut0 (
      .clk (clk), .reset (reset), .bus (if0.slave)
   );
   hazard_control_unit #(.REG_ADDR_W(AW), .START_HALTED(1), .CNT_W(CW)) dut1 (
      .clk (clk), .reset (reset), .bus (if1.slave)
   );

   always #5 clk = ~clk;

   logic [5:0] o0, o1;
   assign o0 = {if0.pipe_ena, if0.pc_disa, if0.if_id_disa, if0.if_id_flush, if0.id_ex_flush, if0.halted};
   assign o1 = {if1.pipe_ena, if1.pc_disa, if1.if_id_disa, if1.if_id_flush, if1.id_ex_flush, if1.halted};

   // Reference model state per instance
   int          m_state [2];
   logic [CW-1:0] m_stall [2];
   logic [CW-1:0] m_flush [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic bit model_lu();
      return ex_mem_read && (ex_rt != 0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   endfunction

   // {pipe_ena, pc_disa, if_id_disa, if_id_flush, id_ex_flush, halted}
   function automatic logic [5:0] model_out(input int st, input bit sh);
      bit ena, lu;
      lu  = model_lu();
      ena = !reset && (st != M_HALTED);
      return {ena, ena && lu, ena && lu, ena && branch_taken && !lu, ena && lu,
              reset ? sh : (st == M_HALTED)};
   endfunction

   function automatic int model_next(input int st, input bit sh);
      if (reset) return sh ? M_HALTED : M_RUN;
      if (st == M_RUN)    return halt_detected ? M_HALTED : M_RUN;
      if (st == M_HALTED) return dbg_run ? M_RUN : (dbg_step ? M_STEP : M_HALTED);
      return M_HALTED;
   endfunction

   // Check both instances mid-cycle, then advance the model across the rising edge.
   task automatic tick();
      logic [5:0] e0, e1;
      int         n0, n1;
      @(negedge clk);
      e0 = model_out(m_state[0], 1'b0);
      e1 = model_out(m_state[1], 1'b1);
      chk("outs_run_inst", 32'(o0), 32'(e0));
      chk("outs_halt_inst", 32'(o1), 32'(e1));
`ifdef HAZARD_COUNTERS_EN
      chk("stall_cnt0", if0.stall_count, m_stall[0]);
      chk("flush_cnt0", if0.flush_count, m_flush[0]);
      chk("stall_cnt1", if1.stall_count, m_stall[1]);
      chk("flush_cnt1", if1.flush_count, m_flush[1]);
`endif
      n0 = model_next(m_state[0], 1'b0);
      n1 = model_next(m_state[1], 1'b1);
      @(posedge clk);
      m_state[0] = n0;
      m_state[1] = n1;
      if (reset) begin
         m_stall[0] = '0; m_flush[0] = '0; m_stall[1] = '0; m_flush[1] = '0;
      end else begin
         if (e0[4]) m_stall[0] = m_stall[0] + 1'b1;
         if (e0[2]) m_flush[0] = m_flush[0] + 1'b1;
         if (e1[4]) m_stall[1] = m_stall[1] + 1'b1;
         if (e1[2]) m_flush[1] = m_flush[1] + 1'b1;
      end
      #1;
   endtask

   task automatic idle_inputs();
      id_rs = '0; id_rt = '0; ex_rt = '0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
      branch_taken = 1'b0; halt_detected = 1'b0; dbg_run = 1'b0; dbg_step = 1'b0;
   endtask

   initial begin
      m_state[0] = M_RUN;    m_state[1] = M_HALTED;
      m_stall[0] = '0; m_flush[0] = '0; m_stall[1] = '0; m_flush[1] = '0;
      reset = 1'b1;
      idle_inputs();
      #1;
      // Reset state
      tick(); tick();
      chk("rst_pipe_ena", 32'(if0.pipe_ena), 32'd0);
      chk("rst_halted_run", 32'(if0.halted), 32'd0);
      chk("rst_halted_sh", 32'(if1.halted), 32'd1);
      reset = 1'b0;
      tick();

      // Load-use on rs, then bubble clears it
      ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; #1;
      chk("lu_pc_disa", 32'(if0.pc_disa), 32'd1);
      chk("lu_if_id_disa", 32'(if0.if_id_disa), 32'd1);
      chk("lu_id_ex_flush", 32'(if0.id_ex_flush), 32'd1);
      chk("lu_if_id_flush", 32'(if0.if_id_flush), 32'd0);
      chk("lu_frozen_inst", 32'(if1.pc_disa), 32'd0);
      tick();
      ex_mem_read = 1'b0; #1;
      chk("lu_gone", 32'(o0[4:1]), 32'd0);
      tick();

      // $zero destination and unused rt
      ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; #1;
      chk("lu_zero_reg", 32'(if0.pc_disa), 32'd0);
      tick();
      ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd1; id_uses_rt = 1'b0; #1;
      chk("lu_rt_unused", 32'(if0.pc_disa), 32'd0);
      tick();
      id_uses_rt = 1'b1; #1;
      chk("lu_rt_used", 32'(if0.pc_disa), 32'd1);
      tick();

      // Branch alone, then branch under load-use
      idle_inputs(); branch_taken = 1'b1; #1;
      chk("br_flush", 32'(if0.if_id_flush), 32'd1);
      chk("br_no_stall", 32'(if0.pc_disa), 32'd0);
      tick();
      ex_mem_read = 1'b1; ex_rt = 5'd3; id_rs = 5'd3; #1;
      chk("br_lu_flush", 32'(if0.if_id_flush), 32'd0);
      chk("br_lu_stall", 32'(if0.pc_disa), 32'd1);
      halt_detected = 1'b1; // halt with a pending LU: LU still driven this cycle
      tick();
      idle_inputs(); #1;
      chk("halt_halted", 32'(if0.halted), 32'd1);
      chk("halt_ena", 32'(if0.pipe_ena), 32'd0);
      tick();

      // Single step: exactly one enabled cycle
      dbg_step = 1'b1;
      tick();
      dbg_step = 1'b0; #1;
      chk("step_ena", 32'(if0.pipe_ena), 32'd1);
      chk("step_not_halted", 32'(if0.halted), 32'd0);
      tick();
      chk("step_back_halted", 32'(if0.halted), 32'd1);
      chk("step_back_ena", 32'(if0.pipe_ena), 32'd0);

      // Resume
      dbg_run = 1'b1;
      tick();
      dbg_run = 1'b0;
      tick(); tick();
      chk("run_sticky", 32'(if0.pipe_ena), 32'd1);

      // Halt, then run+step together: run wins
      halt_detected = 1'b1; tick(); halt_detected = 1'b0;
      dbg_run = 1'b1; dbg_step = 1'b1; tick(); dbg_run = 1'b0; dbg_step = 1'b0; #1;
      chk("run_wins_ena", 32'(if0.pipe_ena), 32'd1);
      chk("run_wins_halted", 32'(if0.halted), 32'd0);

      // Reset in the middle of a step
      halt_detected = 1'b1; tick(); halt_detected = 1'b0;
      dbg_step = 1'b1; tick(); dbg_step = 1'b0;
      reset = 1'b1; branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4; #1;
      chk("mid_step_rst_outs", 32'(o1[5:1]), 32'd0);
      chk("mid_step_rst_halted", 32'(if1.halted), 32'd1);
      tick();
      chk("after_rst_sh", 32'(if1.halted), 32'd1);
      chk("after_rst_run", 32'(if0.halted), 32'd0);
      idle_inputs();
      tick();
      reset = 1'b0;
      tick();

`ifdef HAZARD_COUNTERS_EN
      // Three load-use cycles and two branch flushes
      ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
      repeat (3) tick();
      idle_inputs(); branch_taken = 1'b1;
      repeat (2) tick();
      idle_inputs(); #1;
      chk("cnt_stall3", if0.stall_count, 32'd3);
      chk("cnt_flush2", if0.flush_count, 32'd2);
      reset = 1'b1; tick(); reset = 1'b0; #1;
      chk("cnt_stall_rst", if0.stall_count, 32'd0);
      chk("cnt_flush_rst", if0.flush_count, 32'd0);
      tick();
`endif

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         reset         = ($urandom_range(0, 63) == 0);
         halt_detected = ($urandom_range(0, 15) == 0);
         dbg_run       = ($urandom_range(0, 15) == 0);
         dbg_step      = ($urandom_range(0, 7) == 0);
         ex_mem_read   = $urandom_range(0, 1) == 1;
         ex_rt         = AW'($urandom_range(0, 3));
         id_rs         = AW'($urandom_range(0, 3));
         id_rt         = AW'($urandom_range(0, 3));
         id_uses_rt    = $urandom_range(0, 1) == 1;
         branch_taken  = ($urandom_range(0, 3) == 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Central sequencing controller for the 5-stage MIPS pipeline.
- Generates the ena / disa / flush controls consumed by the IF/ID latch and the other pipe registers, plus the PC stall.
- Detects load-use hazards and taken-branch flushes.
- Runs a debug FSM (RUN / HALTED / STEP), so the debug unit can freeze the pipeline or single-step it.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- START_HALTED, 0, 1 = FSM leaves reset in HALTED; 0 = leaves reset in RUN.
- CNT_W, 32, width of the hazard event counters (only with the optional feature).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs  in  REG_ADDR_W  rs field of the instruction in ID.
- id_rt  in  REG_ADDR_W  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- ex_rt  in  REG_ADDR_W  destination rt of the instruction in EX.
- ex_mem_read  in  1  instruction in EX is a load.
- branch_taken  in  1  branch/jump resolved taken in ID this cycle.
- halt_detected  in  1  HALT opcode reached WB this cycle.
- dbg_run  in  1  single-cycle pulse: resume free run.
- dbg_step  in  1  single-cycle pulse: advance exactly one clock.
- pipe_ena  out  1  global enable to PC and every pipe register.
- pc_disa  out  1  hold PC value.
- if_id_disa  out  1  hold IF/ID contents.
- if_id_flush  out  1  zero IF/ID instruction (NOP).
- id_ex_flush  out  1  insert bubble into ID/EX.
- halted  out  1  FSM is in HALTED.

Behaviour:
- State register: RUN, HALTED, STEP (2 bits). Reset value is RUN, or HALTED when START_HALTED=1.
- All outputs are combinational from the current state and current inputs, with zero latency, so the stall takes effect on the same edge.
- While reset is high: pipe_ena=0, all disa/flush outputs=0, halted reflects the reset target state.
- pipe_ena=1 in RUN and STEP; pipe_ena=0 in HALTED.
- Hazard outputs are forced to 0 whenever pipe_ena=0.
- Load-use condition (LU):
  - ex_mem_read=1 and ex_rt!=0, and
  - ex_rt==id_rs, or (id_uses_rt=1 and ex_rt==id_rt).
- On LU: pc_disa=1, if_id_disa=1, id_ex_flush=1, if_id_flush=0.
- LU lasts exactly one cycle for a single load, because EX holds the bubble next cycle (ex_mem_read=0).
- branch_taken without LU: if_id_flush=1, all other hazard outputs 0.
- LU together with branch_taken: LU wins and the branch is suppressed. The branch re-resolves next cycle with forwarded data.
- Transitions:
  - RUN: halt_detected → HALTED.
  - HALTED: dbg_run → RUN; else dbg_step → STEP; else stay.
  - STEP: always leaves after one cycle. halt_detected → HALTED; else → HALTED. STEP is exactly one enabled clock.
- Simultaneous events:
  - dbg_run and dbg_step together in HALTED: run wins.
  - dbg_run or dbg_step outside HALTED: ignored.
  - halt_detected in RUN with a pending LU: the LU outputs are still driven that cycle, then the FSM enters HALTED.
  - halt_detected while already HALTED: no effect.
- Reset mid-step or mid-stall: returns to the reset state next edge, and no hazard output asserts during reset.

Optional Feature:
- Macro: HAZARD_COUNTERS_EN.
- When defined, adds outputs stall_count and flush_count, both out, CNT_W wide.
  - stall_count increments on each edge where LU and pipe_ena are asserted.
  - flush_count increments on each edge where if_id_flush is asserted.
  - Both clear on reset and wrap at 2^CNT_W.
- When not defined, these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - state encodings ST_RUN=2'd0, ST_HALTED=2'd1, ST_STEP=2'd2;
  - REG_ZERO constant;
  - default REG_ADDR_W.
- One combinational sub-module, load_use_detector: inputs id_rs, id_rt, id_uses_rt, ex_rt, ex_mem_read; output lu. The top-level holds the FSM, output muxing and the optional counters.

Test Plan:
- Load-use on rs: RUN, ex_mem_read=1, ex_rt=5, id_rs=5 → same cycle pc_disa=1, if_id_disa=1, id_ex_flush=1. Next cycle ex_mem_read=0 → all 0.
- Zero-register and unused-rt cases: ex_rt=0 matching id_rs=0 → no stall. ex_rt=7, id_rt=7, id_uses_rt=0 → no stall.
- Branch, then branch with LU: branch_taken=1 alone → if_id_flush=1 only. branch_taken=1 with LU active → if_id_flush=0 and LU outputs asserted.
- Halt and single-step: halt_detected=1 in RUN → next cycle halted=1, pipe_ena=0. dbg_step pulse → exactly one cycle with pipe_ena=1, then halted=1. dbg_run → pipe_ena=1 and it stays 1.
- Simultaneous debug pulses and mid-step reset: dbg_run and dbg_step together in HALTED → RUN. reset during STEP with START_HALTED=1 → HALTED, all outputs 0 during reset.
- Counters (with HAZARD_COUNTERS_EN): 3 LU cycles and 2 branch flushes → stall_count=3, flush_count=2. Reset → both 0.
